// File: rtl/seq_ctrl_unit_pkg.sv
// rtl/seq_ctrl_unit_pkg.sv - shared state encoding and constants for the sequencer
package seq_ctrl_unit_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    PROCESS = 3'd2,
    READY   = 3'd3,
    CLEAR   = 3'd4
  } seqc_state_e;

  localparam logic U_ZERO = 1'b0;
  localparam logic U_ONE  = 1'b1;

  function automatic logic is_busy(input seqc_state_e s);
    return (s == LOAD) || (s == PROCESS);
  endfunction

endpackage

// File: rtl/seq_ctrl_unit_if.sv
// rtl/seq_ctrl_unit_if.sv - control/status bundle between host and sequencer
interface seq_ctrl_unit_if #(
  parameter int LEN_W = 8
);
  logic             i_start;
  logic [LEN_W-1:0] i_len;
  logic             i_abort;
  logic             i_err_clr;
  logic             o_load;
  logic             o_enb;
  logic             o_clr;
  logic             o_rdy;
  logic             o_done;
  logic             o_busy;
  logic             o_err;
  logic [LEN_W-1:0] o_cnt;
  logic [2:0]       o_state;

  modport master (
    output i_start, i_len, i_abort, i_err_clr,
    input  o_load, o_enb, o_clr, o_rdy, o_done, o_busy, o_err, o_cnt, o_state
  );

  modport slave (
    input  i_start, i_len, i_abort, i_err_clr,
    output o_load, o_enb, o_clr, o_rdy, o_done, o_busy, o_err, o_cnt, o_state
  );
endinterface

// File: rtl/seq_ctrl_unit_cycle_counter.sv
// rtl/seq_ctrl_unit_cycle_counter.sv - phase cycle counter with terminal compare
module seq_cycle_counter #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [LEN_W-1:0] i_term,
  output logic [LEN_W-1:0] o_cnt,
  output logic             o_at_term
);

  logic [LEN_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt     = r_cnt;
  assign o_at_term = (r_cnt == i_term);

endmodule

// File: rtl/seq_ctrl_unit.sv
// rtl/seq_ctrl_unit.sv - load/process/ready/clear sequencer for the iterative datapath
module seq_ctrl_unit
  import seq_ctrl_unit_pkg::*;
#(
  parameter int LEN_W     = 8,
  parameter int OP_CYCLES = 8,
  parameter int RDY_HOLD  = 2,
  parameter int BACK2BACK = 1
) (
  input logic           clk,
  input logic           rst,
  seq_ctrl_unit_if.slave bus
);

  if (OP_CYCLES < 1 || OP_CYCLES > (2 ** LEN_W) - 1) begin : g_bad_op_cycles
    $error("seq_ctrl_unit: OP_CYCLES out of range");
  end
  if (RDY_HOLD < 1 || RDY_HOLD > (2 ** LEN_W)) begin : g_bad_rdy_hold
    $error("seq_ctrl_unit: RDY_HOLD out of range");
  end

  seqc_state_e      r_state;
  logic [LEN_W-1:0] r_len_q;
  logic             r_err;

  logic [LEN_W-1:0] w_len_sel;
  logic [LEN_W-1:0] w_term;
  logic [LEN_W-1:0] w_cnt;
  logic             w_at_term;
  logic             w_b2b;
  logic             w_cnt_run;
  logic             w_start_bad;

  assign w_len_sel   = (bus.i_len == '0) ? LEN_W'(OP_CYCLES) : bus.i_len;
  assign w_term      = (r_state == READY) ? LEN_W'(RDY_HOLD - 1) : (r_len_q - 1'b1);
  assign w_b2b       = (BACK2BACK != 0) && bus.i_start;
  assign w_start_bad = bus.i_start && (is_busy(r_state) || (r_state == READY && BACK2BACK == 0));

  // The counter only advances while staying in PROCESS/READY; every phase change restarts it at 0.
  assign w_cnt_run = ((r_state == PROCESS) && !bus.i_abort && !w_at_term) ||
                     ((r_state == READY) && !w_at_term && !w_b2b);

  seq_cycle_counter #(.LEN_W(LEN_W)) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (!w_cnt_run),
    .i_en      (w_cnt_run),
    .i_term    (w_term),
    .o_cnt     (w_cnt),
    .o_at_term (w_at_term)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_len_q <= '0;
      r_err   <= U_ZERO;
    end else begin
      case (r_state)
        IDLE, CLEAR: begin
          if (bus.i_start) begin
            r_state <= LOAD;
            r_len_q <= w_len_sel;
          end else begin
            r_state <= IDLE;
          end
        end
        LOAD:    r_state <= bus.i_abort ? CLEAR : PROCESS;
        PROCESS: begin
          if (bus.i_abort)    r_state <= CLEAR;
          else if (w_at_term) r_state <= READY;
        end
        READY: begin
          if (w_b2b) begin
            r_state <= LOAD;
            r_len_q <= w_len_sel;
          end else if (w_at_term) begin
            r_state <= CLEAR;
          end
        end
        default: r_state <= IDLE;
      endcase

      if (w_start_bad)        r_err <= U_ONE;
      else if (bus.i_err_clr) r_err <= U_ZERO;
    end
  end

  always_comb begin
    bus.o_load  = U_ZERO;
    bus.o_enb   = U_ZERO;
    bus.o_clr   = U_ZERO;
    bus.o_rdy   = U_ZERO;
    bus.o_done  = U_ZERO;
    bus.o_busy  = U_ZERO;
    bus.o_err   = U_ZERO;
    bus.o_cnt   = '0;
    bus.o_state = IDLE;
    case (r_state)
      IDLE, LOAD, PROCESS, READY, CLEAR: begin
        bus.o_load  = (r_state == LOAD);
        bus.o_enb   = (r_state == PROCESS);
        bus.o_clr   = (r_state == CLEAR);
        bus.o_rdy   = (r_state == READY);
        bus.o_done  = (r_state == READY) && (w_cnt == '0);
        bus.o_busy  = is_busy(r_state);
        bus.o_err   = r_err;
        bus.o_cnt   = w_cnt;
        bus.o_state = r_state;
      end
      default: ;
    endcase
  end

endmodule
